// File: rtl/counter_min_hour.sv
// Minutes/hours counter driven by the seconds carry level, with a three-state
// button-driven time-set mode (RUN -> SET_MIN -> SET_HOUR -> RUN).
module counter_min_hour #(
  parameter int MIN_MAX  = 59,
  parameter int HOUR_MAX = 23,
  parameter int W_MIN    = 6,
  parameter int W_HOUR   = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              carry_sec,
  input  logic              mode_btn,
  input  logic              set_btn,
  output logic [W_MIN-1:0]  count_min,
  output logic [W_HOUR-1:0] count_hour,
  output logic [1:0]        set_state,
  output logic              carry_min,
  output logic              carry_day
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_MIN  = 2'b01,
    ST_SET_HOUR = 2'b10
  } state_t;

  localparam logic [W_MIN-1:0]  MIN_LAST  = W_MIN'(MIN_MAX);
  localparam logic [W_HOUR-1:0] HOUR_LAST = W_HOUR'(HOUR_MAX);
  localparam logic [W_MIN-1:0]  MIN_ONE   = W_MIN'(1);
  localparam logic [W_HOUR-1:0] HOUR_ONE  = W_HOUR'(1);

  // Out-of-range values are treated as the last value so they wrap to zero.
  function automatic logic [W_MIN-1:0] inc_min(input logic [W_MIN-1:0] v);
    logic [W_MIN-1:0] r;
    if (v >= MIN_LAST) r = {W_MIN{1'b0}};
    else               r = v + MIN_ONE;
    return r;
  endfunction

  function automatic logic [W_HOUR-1:0] inc_hour(input logic [W_HOUR-1:0] v);
    logic [W_HOUR-1:0] r;
    if (v >= HOUR_LAST) r = {W_HOUR{1'b0}};
    else                r = v + HOUR_ONE;
    return r;
  endfunction

  state_t            state, state_nxt;
  logic              carry_q, mode_q, set_q;
  logic              carry_rise, mode_rise, set_rise;
  logic [W_MIN-1:0]  min_nxt;
  logic [W_HOUR-1:0] hour_nxt;
  logic              carry_min_nxt, carry_day_nxt;

  assign carry_rise = carry_sec & ~carry_q;
  assign mode_rise  = mode_btn  & ~mode_q;
  assign set_rise   = set_btn   & ~set_q;
  assign set_state  = state;

  // Edge history resets high so a level already present at release is not an edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      carry_q <= 1'b1;
      mode_q  <= 1'b1;
      set_q   <= 1'b1;
    end else begin
      carry_q <= carry_sec;
      mode_q  <= mode_btn;
      set_q   <= set_btn;
    end
  end

  // Next-state, count and carry-pulse logic.
  always_comb begin
    state_nxt     = state;
    min_nxt       = count_min;
    hour_nxt      = count_hour;
    carry_min_nxt = 1'b0;
    carry_day_nxt = 1'b0;
    case (state)
      ST_RUN: begin
        if (mode_rise) state_nxt = ST_SET_MIN;
        else           state_nxt = ST_RUN;
        if (carry_rise) begin
          min_nxt = inc_min(count_min);
          if (count_min >= MIN_LAST) begin
            carry_min_nxt = 1'b1;
            hour_nxt      = inc_hour(count_hour);
            if (count_hour >= HOUR_LAST) carry_day_nxt = 1'b1;
            else                         carry_day_nxt = 1'b0;
          end else begin
            carry_min_nxt = 1'b0;
          end
        end else begin
          min_nxt = count_min;
        end
      end
      // A mode edge wins over a simultaneous set edge: the increment is dropped.
      ST_SET_MIN: begin
        if (mode_rise)     state_nxt = ST_SET_HOUR;
        else if (set_rise) min_nxt   = inc_min(count_min);
        else               state_nxt = ST_SET_MIN;
      end
      ST_SET_HOUR: begin
        if (mode_rise)     state_nxt = ST_RUN;
        else if (set_rise) hour_nxt  = inc_hour(count_hour);
        else               state_nxt = ST_SET_HOUR;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // State, counts and carry pulses are all registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      count_min  <= {W_MIN{1'b0}};
      count_hour <= {W_HOUR{1'b0}};
      carry_min  <= 1'b0;
      carry_day  <= 1'b0;
    end else begin
      state      <= state_nxt;
      count_min  <= min_nxt;
      count_hour <= hour_nxt;
      carry_min  <= carry_min_nxt;
      carry_day  <= carry_day_nxt;
    end
  end

endmodule

// File: tb/tb_counter_min_hour.sv
// Scoreboard bench for counter_min_hour: directed vectors push expected outputs,
// a monitor pops and compares them one cycle later.
module tb_counter_min_hour;

  logic       clock;
  logic       reset_n;
  logic       carry_sec;
  logic       mode_btn;
  logic       set_btn;
  logic [5:0] count_min;
  logic [4:0] count_hour;
  logic [1:0] set_state;
  logic       carry_min;
  logic       carry_day;

  typedef struct {
    string      tag;
    logic [5:0] min;
    logic [4:0] hour;
    logic [1:0] st;
    logic       cmin;
    logic       cday;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  counter_min_hour dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .carry_sec  (carry_sec),
    .mode_btn   (mode_btn),
    .set_btn    (set_btn),
    .count_min  (count_min),
    .count_hour (count_hour),
    .set_state  (set_state),
    .carry_min  (carry_min),
    .carry_day  (carry_day)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: outputs settle right after each edge; compare against the oldest expectation.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (count_min !== e.min || count_hour !== e.hour || set_state !== e.st ||
          carry_min !== e.cmin || carry_day !== e.cday) begin
        errors++;
        $display("FAIL %s: got min=%0d hour=%0d st=%0d cmin=%0b cday=%0b, expected min=%0d hour=%0d st=%0d cmin=%0b cday=%0b",
                 e.tag, count_min, count_hour, set_state, carry_min, carry_day,
                 e.min, e.hour, e.st, e.cmin, e.cday);
      end
    end
  end

  // One cycle: drive inputs between edges, expect the given outputs after the next edge.
  task automatic cyc(input string tag, input logic rst, input logic c, input logic m,
                     input logic s, input int em, input int eh, input int es,
                     input logic ecm, input logic ecd);
    exp_t e;
    @(posedge clock);
    #2;
    reset_n   = rst;
    carry_sec = c;
    mode_btn  = m;
    set_btn   = s;
    e.tag  = tag;
    e.min  = 6'(em);
    e.hour = 5'(eh);
    e.st   = 2'(es);
    e.cmin = ecm;
    e.cday = ecd;
    exp_q.push_back(e);
  endtask

  // Button press: one cycle high, one cycle low, counts stable through release.
  task automatic press(input string tag, input logic m, input logic s,
                       input int em, input int eh, input int es);
    cyc(tag, 1'b1, 1'b0, m, s, em, eh, es, 1'b0, 1'b0);
    cyc(tag, 1'b1, 1'b0, 1'b0, 1'b0, em, eh, es, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; carry_sec = 1'b1; mode_btn = 1'b0; set_btn = 1'b0;

    // Reset with carry already high: no step at release.
    cyc("reset", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    cyc("release_carry_high", 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    cyc("carry_held", 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    cyc("carry_low", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

    // Multi-clock carry level gives exactly one minute step per rise.
    for (int k = 1; k <= 3; k++) begin
      cyc("carry_step", 1'b1, 1'b1, 1'b0, 1'b0, k, 0, 0, 1'b0, 1'b0);
      for (int j = 0; j < 4; j++)
        cyc("carry_level", 1'b1, 1'b1, 1'b0, 1'b0, k, 0, 0, 1'b0, 1'b0);
      cyc("carry_fall", 1'b1, 1'b0, 1'b0, 1'b0, k, 0, 0, 1'b0, 1'b0);
    end
    press("run_set_ignored", 1'b0, 1'b1, 3, 0, 0);

    // Restart from 00:00 and walk through set mode with wrap-around.
    cyc("reset2", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    cyc("release2", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    press("to_set_min", 1'b1, 1'b0, 0, 0, 1);
    for (int i = 1; i <= 61; i++) press("set_min_inc", 1'b0, 1'b1, i % 60, 0, 1);
    press("to_set_hour", 1'b1, 1'b0, 1, 0, 2);
    for (int i = 1; i <= 25; i++) press("set_hour_inc", 1'b0, 1'b1, 1, i % 24, 2);
    press("to_run", 1'b1, 1'b0, 1, 1, 0);

    // Carry rise in SET_MIN is discarded; set+mode together advances without incrementing.
    press("to_set_min_b", 1'b1, 1'b0, 1, 1, 1);
    cyc("set_min_carry", 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 1, 1'b0, 1'b0);
    cyc("set_min_carry_low", 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 1, 1'b0, 1'b0);
    press("mode_and_set", 1'b1, 1'b1, 1, 1, 2);

    // Preload 23:59 and roll over the day.
    for (int i = 2; i <= 23; i++) press("hour_to_23", 1'b0, 1'b1, 1, i, 2);
    press("to_run_b", 1'b1, 1'b0, 1, 23, 0);
    press("to_set_min_c", 1'b1, 1'b0, 1, 23, 1);
    for (int i = 2; i <= 59; i++) press("min_to_59", 1'b0, 1'b1, i, 23, 1);
    press("to_set_hour_c", 1'b1, 1'b0, 59, 23, 2);
    press("to_run_c", 1'b1, 1'b0, 59, 23, 0);
    cyc("day_wrap", 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1);
    cyc("day_wrap_pulse_end", 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    cyc("day_wrap_carry_low", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

    // Preload 00:59 and roll over the hour.
    press("to_set_min_d", 1'b1, 1'b0, 0, 0, 1);
    for (int i = 1; i <= 59; i++) press("min_to_59_d", 1'b0, 1'b1, i, 0, 1);
    press("to_set_hour_d", 1'b1, 1'b0, 59, 0, 2);
    press("to_run_d", 1'b1, 1'b0, 59, 0, 0);
    cyc("hour_wrap", 1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1'b1, 1'b0);
    cyc("hour_wrap_pulse_end", 1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1'b0, 1'b0);
    cyc("hour_wrap_carry_low", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 0, 1'b0, 1'b0);

    // Carry and mode together in RUN: step applied and state moves on.
    cyc("carry_and_mode", 1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 1, 1'b0, 1'b0);
    cyc("carry_and_mode_low", 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 1, 1'b0, 1'b0);

    // Reset in SET_HOUR returns to 00:00 RUN.
    press("to_set_hour_e", 1'b1, 1'b0, 1, 1, 2);
    cyc("reset_mid_set", 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0);
    cyc("release3_set_high", 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0);
    cyc("post_reset_idle", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clock);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
